mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
- Iterative multiply/divide unit in the execute stage, directly downstream of the register file.
- Consumes the two register read values (rs/rt) and produces MIPS HI/LO results over a fixed latency.
- Stalled by the hazard logic while busy; implements MULT, MULTU, DIV, DIVU, MTHI, MTLO and holds HI/LO for MFHI/MFLO.

Parameters:
- DATAW, 32, operand and HI/LO width. Must be even; the iteration count equals DATAW.

Ports:
- clk      in   1       rising-edge clock
- reset    in   1       synchronous, active-high reset
- start    in   1       launch the operation selected by op; sampled only in IDLE
- op       in   3       0=MULT 1=MULTU 2=DIV 3=DIVU 4=MADD 5=MADDU (4/5 only with the optional feature); others are ignored
- rs_val   in   DATAW   operand A (multiplicand / dividend)
- rt_val   in   DATAW   operand B (multiplier / divisor)
- wr_hi    in   1       MTHI strobe
- wr_lo    in   1       MTLO strobe
- wr_data  in   DATAW   MTHI/MTLO data
- busy     out  1       operation in flight
- done     out  1       one-cycle pulse: HI/LO just updated by an operation
- hi       out  DATAW   HI register
- lo       out  DATAW   LO register

Behaviour:
- Reset (synchronous, active-high): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0. Reset mid-operation aborts immediately and leaves no partial HI/LO update.
- States: IDLE, ITER, FIX.
- IDLE, start=1 with a valid op (cycle 0):
  - Latch op.
  - Signed ops: latch |rs_val| and |rt_val|, plus the result sign and remainder sign.
  - Set counter=0 and go to ITER.
- ITER (cycles 1..DATAW): one step per cycle; counter increments; after counter=DATAW-1 go to FIX.
  - Multiply: shift-add over a 2*DATAW accumulator.
  - Divide: restoring, one quotient bit per cycle.
- FIX (cycle DATAW+1):
  - Apply sign correction. Product is negated if the signs differ. Quotient is negated if the signs differ. Remainder takes the dividend's sign.
  - Write hi/lo at the end of this cycle, then go to IDLE.
- Cycle DATAW+2: done=1 for exactly one cycle; hi/lo visible.
- busy=1 in ITER and FIX (cycles 1..DATAW+1); busy=0 in IDLE.
- Latency from start to done is DATAW+2 cycles (34 at the default).
- Multiply: {hi,lo} = full 2*DATAW product.
- Divide: lo = quotient, hi = remainder.
- Divide by zero:
  - Same latency; no sign correction.
  - lo = all ones, hi = rs_val as latched.
- Signed overflow (DIV of 0x80000000 by 0xFFFFFFFF): lo = 0x80000000, hi = 0.
- start while busy: ignored. Invalid op: ignored; stays IDLE.
- wr_hi/wr_lo in IDLE: update on that edge; both may be set together.
- wr_hi/wr_lo while busy: ignored.
- start and wr_hi/wr_lo in the same IDLE cycle: start wins and the write is dropped.
- rs_val/rt_val are don't-care after cycle 0.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: op 4 (MADD, signed) and op 5 (MADDU) run as MULT/MULTU. In FIX, {hi,lo} = {hi,lo} + signed product, modulo 2^(2*DATAW). Latency is unchanged.
- Undefined: op 4/5 are invalid and ignored; no adder is synthesized.

Decomposition:
- Package mdu_pkg:
  - op code constants OP_MULT..OP_MADDU;
  - state encoding IDLE/ITER/FIX;
  - default DATAW;
  - the divide-by-zero LO value.
- Sub-module mdu_sign_fix (combinational):
  - inputs: raw 2*DATAW result, negate-low flag, negate-high flag, mode;
  - output: corrected {hi,lo}.
- The FSM, counter and datapath stay in mdu_iter.

Test Plan:
- MULT rs=0xFFFFFFFD (-3), rt=5 → busy 1 for 33 cycles, done in cycle 34; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIVU rs=100, rt=7 → lo=14, hi=2. DIV rs=-7, rt=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU rs=0x1234, rt=0 → lo=0xFFFFFFFF, hi=0x1234. DIV 0x80000000 by 0xFFFFFFFF → lo=0x80000000, hi=0.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=1; then, in the same run:
  - a second start in cycle 10 is ignored;
  - wr_hi in cycle 12 is ignored;
  - MTLO 0xABCD in IDLE → lo=0xABCD, hi unchanged.
- DIV started, reset asserted in cycle 15 → next cycle busy=0, hi=lo=0, and no done pulse follows.
- MDU_MADD_EN defined: after MTHI 0, MTLO 10, run MADD 3×(-2) → hi=0, lo=4. MDU_MADD_EN undefined: op=4 with start → busy stays 0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM
// states, datapath modes and the divide-by-zero LO fill.
package mdu_pkg;

  localparam int DEFAULT_DATAW = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MADD  = 3'd4;
  localparam logic [2:0] OP_MADDU = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_e;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } mode_e;

  // Divide-by-zero LO is this bit replicated across the full width (all ones).
  localparam logic DIV0_LO_FILL = 1'b1;

endpackage

// File: rtl/mdu_iter_if.sv
// Operation/result bundle between the execute stage and the multiply/divide unit.
interface mdu_iter_if
  import mdu_pkg::*;
#(
  parameter int DATAW = DEFAULT_DATAW
) ();

  logic             start;
  logic [2:0]       op;
  logic [DATAW-1:0] rs_val;
  logic [DATAW-1:0] rt_val;
  logic             wr_hi;
  logic             wr_lo;
  logic [DATAW-1:0] wr_data;
  logic             busy;
  logic             done;
  logic [DATAW-1:0] hi;
  logic [DATAW-1:0] lo;

  modport master (
    output start, op, rs_val, rt_val, wr_hi, wr_lo, wr_data,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val, wr_hi, wr_lo, wr_data,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/mdu_sign_fix.sv
// Sign restoration for the magnitude-only datapath: negates the full product,
// or the quotient and remainder independently.
module mdu_sign_fix
  import mdu_pkg::*;
#(
  parameter int DATAW = DEFAULT_DATAW
) (
  input  logic [2*DATAW-1:0] raw,
  input  logic               neg_lo,
  input  logic               neg_hi,
  input  mode_e              mode,
  output logic [2*DATAW-1:0] fixed
);

  logic [DATAW-1:0] lo_part;
  logic [DATAW-1:0] hi_part;

  always_comb begin
    lo_part = raw[DATAW-1:0];
    hi_part = raw[2*DATAW-1:DATAW];
    if (neg_lo) lo_part = -raw[DATAW-1:0];
    if (neg_hi) hi_part = -raw[2*DATAW-1:DATAW];
    fixed = {hi_part, lo_part};
    if (mode == MODE_MUL) begin
      fixed = neg_lo ? -raw : raw;
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative MIPS multiply/divide unit with HI/LO registers, DATAW+2 cycle latency.
// Define MDU_MADD_EN to add MADD/MADDU (accumulate the product into {hi,lo}).
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int DATAW = DEFAULT_DATAW
) (
  input logic       clk,
  input logic       reset,
  mdu_iter_if.slave bus
);

  localparam int CW = $clog2(DATAW + 1);

  state_e             state_reg;
  mode_e              mode_reg;
  logic [CW-1:0]      count_reg;
  logic [DATAW-1:0]   opnd_reg;
  logic [2*DATAW-1:0] acc_reg;
  logic               neg_lo_reg;
  logic               neg_hi_reg;
  logic               div0_reg;
  logic               busy_reg;
  logic               done_reg;
  logic [DATAW-1:0]   hi_reg;
  logic [DATAW-1:0]   lo_reg;
`ifdef MDU_MADD_EN
  logic               madd_reg;
`endif

  logic               op_valid;
  logic               op_signed;
  logic               op_div;
  logic               a_neg;
  logic               b_neg;
  logic [DATAW-1:0]   a_abs;
  logic [DATAW-1:0]   b_abs;
  logic [DATAW:0]     mul_sum;
  logic [2*DATAW-1:0] mul_next;
  logic [DATAW:0]     div_part;
  logic               div_ge;
  logic [DATAW-1:0]   div_rem;
  logic [2*DATAW-1:0] div_next;
  logic [2*DATAW-1:0] fixed;
  logic [2*DATAW-1:0] result;

  always_comb begin
    op_valid  = 1'b0;
    op_signed = 1'b0;
    op_div    = 1'b0;
    case (bus.op)
      OP_MULT:  begin op_valid = 1'b1; op_signed = 1'b1; end
      OP_MULTU: op_valid = 1'b1;
      OP_DIV:   begin op_valid = 1'b1; op_signed = 1'b1; op_div = 1'b1; end
      OP_DIVU:  begin op_valid = 1'b1; op_div = 1'b1; end
`ifdef MDU_MADD_EN
      OP_MADD:  begin op_valid = 1'b1; op_signed = 1'b1; end
      OP_MADDU: op_valid = 1'b1;
`endif
      default:  op_valid = 1'b0;
    endcase
  end

  // The iteration runs on magnitudes; signs are restored in FIX.
  assign a_neg = op_signed & bus.rs_val[DATAW-1];
  assign b_neg = op_signed & bus.rt_val[DATAW-1];
  assign a_abs = a_neg ? -bus.rs_val : bus.rs_val;
  assign b_abs = b_neg ? -bus.rt_val : bus.rt_val;

  // Multiply: acc = {partial, multiplier}; add the multiplicand on the LSB, then shift right.
  assign mul_sum  = {1'b0, acc_reg[2*DATAW-1:DATAW]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
  assign mul_next = {mul_sum, acc_reg[DATAW-1:1]};

  // Divide: acc = {remainder, dividend/quotient}; shift left, trial-subtract the divisor.
  assign div_part = {acc_reg[2*DATAW-1:DATAW], acc_reg[DATAW-1]};
  assign div_ge   = div_part >= {1'b0, opnd_reg};
  assign div_rem  = div_ge ? div_part[DATAW-1:0] - opnd_reg : div_part[DATAW-1:0];
  assign div_next = {div_rem, acc_reg[DATAW-2:0], div_ge};

  mdu_sign_fix #(.DATAW(DATAW)) u_sign_fix (
    .raw    (acc_reg),
    .neg_lo (neg_lo_reg),
    .neg_hi (neg_hi_reg),
    .mode   (mode_reg),
    .fixed  (fixed)
  );

  always_comb begin
    result = fixed;
    if (div0_reg) result[DATAW-1:0] = {DATAW{DIV0_LO_FILL}};
`ifdef MDU_MADD_EN
    if (madd_reg) result = {hi_reg, lo_reg} + fixed;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      mode_reg   <= MODE_MUL;
      count_reg  <= '0;
      opnd_reg   <= '0;
      acc_reg    <= '0;
      neg_lo_reg <= 1'b0;
      neg_hi_reg <= 1'b0;
      div0_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
`ifdef MDU_MADD_EN
      madd_reg   <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start && op_valid) begin
            mode_reg   <= op_div ? MODE_DIV : MODE_MUL;
            opnd_reg   <= op_div ? b_abs : a_abs;
            acc_reg    <= {{DATAW{1'b0}}, (op_div ? a_abs : b_abs)};
            neg_lo_reg <= (a_neg ^ b_neg) & ~(op_div && bus.rt_val == '0);
            neg_hi_reg <= a_neg;
            div0_reg   <= op_div && bus.rt_val == '0;
`ifdef MDU_MADD_EN
            madd_reg   <= (bus.op == OP_MADD) || (bus.op == OP_MADDU);
`endif
            count_reg  <= '0;
            busy_reg   <= 1'b1;
            state_reg  <= ITER;
          end else begin
            if (bus.wr_hi) hi_reg <= bus.wr_data;
            if (bus.wr_lo) lo_reg <= bus.wr_data;
          end
        end
        ITER: begin
          acc_reg   <= (mode_reg == MODE_DIV) ? div_next : mul_next;
          count_reg <= count_reg + 1'b1;
          if (count_reg == CW'(DATAW - 1)) state_reg <= FIX;
        end
        FIX: begin
          hi_reg    <= result[2*DATAW-1:DATAW];
          lo_reg    <= result[DATAW-1:0];
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.hi   = hi_reg;
  assign bus.lo   = lo_reg;

endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter: directed vectors with literal expectations, plus an
// arithmetic HI/LO model checked against the DUT on every cycle.
module tb_mdu_iter;
  import mdu_pkg::*;

  localparam int DATAW = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  bit   chk_en = 1'b0;

  mdu_iter_if #(.DATAW(DATAW)) bus ();

  mdu_iter #(.DATAW(DATAW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit op_ok(input logic [2:0] o);
`ifdef MDU_MADD_EN
    return o <= 3'd5;
`else
    return o <= 3'd3;
`endif
  endfunction

  function automatic logic [63:0] model_res(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b, input logic [63:0] hilo);
    int ia, ib;
    longint pa, pb;
    logic [63:0] r;
    ia = a;
    ib = b;
    pa = ia;
    pb = ib;
    case (o)
      3'd0: r = pa * pb;
      3'd1: r = {32'h0, a} * {32'h0, b};
      3'd2: begin
        if (b == 32'h0) r = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
        else r = {ia % ib, ia / ib};
      end
      3'd3: begin
        if (b == 32'h0) r = {a, 32'hFFFF_FFFF};
        else r = {a % b, a / b};
      end
      3'd4: r = hilo + 64'(pa * pb);
      3'd5: r = hilo + {32'h0, a} * {32'h0, b};
      default: r = hilo;
    endcase
    return r;
  endfunction

  logic [31:0] m_hi = '0, m_lo = '0;
  logic        m_done = 1'b0;
  int          m_left = 0;
  logic [2:0]  p_op = '0;
  logic [31:0] p_a = '0, p_b = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_hi <= '0; m_lo <= '0; m_done <= 1'b0; m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          {m_hi, m_lo} <= model_res(p_op, p_a, p_b, {m_hi, m_lo});
          m_done <= 1'b1;
        end
      end else if (bus.start && op_ok(bus.op)) begin
        p_op <= bus.op; p_a <= bus.rs_val; p_b <= bus.rt_val;
        m_left <= DATAW + 1;
      end else begin
        if (bus.wr_hi) m_hi <= bus.wr_data;
        if (bus.wr_lo) m_lo <= bus.wr_data;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_busy", 64'(bus.busy), 64'(m_left > 0));
      check("cyc_done", 64'(bus.done), 64'(m_done));
      check("cyc_hi", 64'(bus.hi), 64'(m_hi));
      check("cyc_lo", 64'(bus.lo), 64'(m_lo));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input int start_cyc, input int wrhi_cyc, input int rst_cyc, input bit wr0);
    int done_cyc = -1;
    int busy_cnt = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.rs_val = a; bus.rt_val = b;
    bus.wr_hi = wr0; bus.wr_data = 32'h55;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      bus.start = 1'b0; bus.wr_hi = 1'b0; reset = 1'b0;
      bus.rs_val = $urandom; bus.rt_val = $urandom;
      if (bus.done && done_cyc < 0) done_cyc = n;
      if (bus.busy) busy_cnt++;
      if (done_cyc > 0) break;
      if (rst_cyc > 0 && n == rst_cyc + 1) begin
        check({name, "_rst_busy"}, 64'(bus.busy), 64'(0));
        check({name, "_rst_hi"}, 64'(bus.hi), 64'(0));
        check({name, "_rst_lo"}, 64'(bus.lo), 64'(0));
      end
      if (n == start_cyc) begin
        bus.start = 1'b1; bus.op = OP_MULT; bus.rs_val = 32'h7; bus.rt_val = 32'h9;
      end
      if (n == wrhi_cyc) begin
        bus.wr_hi = 1'b1; bus.wr_data = 32'hDEAD_BEEF;
      end
      if (n == rst_cyc) reset = 1'b1;
    end
    if (rst_cyc > 0) begin
      check({name, "_no_done"}, 64'(done_cyc < 0), 64'(1));
      $display("op=%0d rs=%h rt=%h aborted by reset in cycle %0d", o, a, b, rst_cyc);
    end else begin
      check({name, "_latency"}, 64'(done_cyc), 64'(34));
      check({name, "_busy_cycles"}, 64'(busy_cnt), 64'(33));
      check({name, "_hi"}, 64'(bus.hi), 64'(exp_hi));
      check({name, "_lo"}, 64'(bus.lo), 64'(exp_lo));
      $display("op=%0d rs=%h rt=%h -> hi=%h lo=%h latency=%0d", o, a, b, bus.hi, bus.lo, done_cyc);
    end
  endtask

  task automatic mt(input bit h, input bit l, input logic [31:0] d,
                    input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    @(negedge clk);
    bus.wr_hi = h; bus.wr_lo = l; bus.wr_data = d;
    @(negedge clk);
    bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
    check("mt_hi", 64'(bus.hi), 64'(exp_hi));
    check("mt_lo", 64'(bus.lo), 64'(exp_lo));
    $display("mthi=%0d mtlo=%0d data=%h -> hi=%h lo=%h", h, l, d, bus.hi, bus.lo);
  endtask

  task automatic try_invalid(input logic [2:0] o);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.rs_val = 32'd3; bus.rt_val = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    check("invalid_busy", 64'(bus.busy), 64'(0));
    @(negedge clk);
    check("invalid_busy2", 64'(bus.busy), 64'(0));
    $display("op=%0d start ignored, busy=%0d", o, bus.busy);
  endtask

  initial begin
    bus.start = 1'b0; bus.op = '0; bus.rs_val = '0; bus.rt_val = '0;
    bus.wr_hi = 1'b0; bus.wr_lo = 1'b0; bus.wr_data = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    check("reset_busy", 64'(bus.busy), 64'(0));
    check("reset_done", 64'(bus.done), 64'(0));
    check("reset_hi", 64'(bus.hi), 64'(0));
    check("reset_lo", 64'(bus.lo), 64'(0));

    run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0, 0, 0, 1'b0);
    run_op("mult_nn", OP_MULT, 32'hFFFF_FFFC, 32'hFFFF_FFFB, 32'h0, 32'd20, 0, 0, 0, 1'b0);
    run_op("multu_big", OP_MULTU, 32'h8000_0000, 32'd2, 32'h1, 32'h0, 0, 0, 0, 1'b0);
    run_op("divu", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 0, 0, 0, 1'b0);
    run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0, 0, 1'b0);
    run_op("div_negdiv", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 0, 0, 0, 1'b0);
    run_op("divu_zero", OP_DIVU, 32'h1234, 32'h0, 32'h1234, 32'hFFFF_FFFF, 0, 0, 0, 1'b0);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 0, 0, 0, 1'b0);
    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 10, 12, 0, 1'b0);
    mt(1'b0, 1'b1, 32'hABCD, 32'hFFFF_FFFE, 32'hABCD);
    mt(1'b1, 1'b1, 32'h1122, 32'h1122, 32'h1122);
    run_op("start_vs_wr", OP_DIVU, 32'd9, 32'd3, 32'd0, 32'd3, 0, 0, 0, 1'b1);
    try_invalid(3'd6);
`ifdef MDU_MADD_EN
    mt(1'b1, 1'b0, 32'h0, 32'h0, 32'd3);
    mt(1'b0, 1'b1, 32'd10, 32'h0, 32'd10);
    run_op("madd", OP_MADD, 32'd3, 32'hFFFF_FFFE, 32'h0, 32'd4, 0, 0, 0, 1'b0);
`else
    try_invalid(OP_MADD);
`endif
    run_op("div_reset", OP_DIV, 32'h55, 32'd3, 32'h0, 32'h0, 0, 0, 15, 1'b0);
    run_op("after_reset", OP_MULT, 32'hFFFF_FFFC, 32'hFFFF_FFFB, 32'h0, 32'd20, 0, 0, 0, 1'b0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
